// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: issues pipelined memory requests under a credit limit
// and buffers in-order responses with their PCs in a small prefetch queue.
module fetch_prefetch #(
   parameter int                ADDR_W            = 32,
   parameter int                DATA_W            = 32,
   parameter int                DEPTH             = 4,
   parameter int                PC_INC            = 1,
   parameter logic [ADDR_W-1:0] RESET_ADDRESS     = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] INTERRUPT_ADDRESS = 32'h0000_0100
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_irq,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   input  logic              i_stall,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_ready,
   input  logic              i_imem_rvalid,
   input  logic [DATA_W-1:0] i_imem_rdata,
   output logic              o_inst_valid,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_inst_pc,
   output logic [ADDR_W-1:0] o_inst_pc_plus
);

   localparam int                PTR_W = $clog2(DEPTH);
   localparam int                CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_resp_pc;
   logic [ADDR_W-1:0] r_q_pc   [DEPTH];
   logic [DATA_W-1:0] r_q_data [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_discard;

   logic              w_flush;
   logic              w_accept;
   logic              w_drop;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W:0]    w_credit_sum;
   logic [ADDR_W-1:0] w_flush_pc;

   assign w_flush      = i_irq | i_redirect;
   assign w_flush_pc   = i_irq ? INTERRUPT_ADDRESS : i_redirect_pc;
   assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};

   // Credits cover both buffered and in-flight entries, so a response always has a slot.
   assign o_imem_req  = i_rst_n & ~w_flush & (w_credit_sum < (CNT_W+1)'(DEPTH));
   assign o_imem_addr = r_fetch_pc;
   assign w_accept    = o_imem_req & i_imem_ready;

   assign w_drop = i_imem_rvalid & (r_discard != '0);
   assign w_push = i_imem_rvalid & (r_discard == '0) & ~w_flush;
   assign w_pop  = o_inst_valid & ~i_stall & ~w_flush;

   assign o_inst_valid   = (r_count != '0);
   assign o_inst         = o_inst_valid ? r_q_data[r_rd_ptr] : '0;
   assign o_inst_pc      = o_inst_valid ? r_q_pc[r_rd_ptr]   : '0;
   assign o_inst_pc_plus = o_inst_pc + INC;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_pc    <= RESET_ADDRESS;
         r_resp_pc     <= RESET_ADDRESS;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else if (w_flush) begin
         // Every in-flight request (already-doomed ones included) must now be dropped.
         r_fetch_pc    <= w_flush_pc;
         r_resp_pc     <= w_flush_pc;
         r_count       <= '0;
         r_rd_ptr      <= r_wr_ptr;
         r_outstanding <= r_outstanding - CNT_W'(i_imem_rvalid);
         r_discard     <= r_outstanding - CNT_W'(i_imem_rvalid);
      end else begin
         if (w_accept)
            r_fetch_pc <= r_fetch_pc + INC;
         if (w_push) begin
            r_resp_pc <= r_resp_pc + INC;
            r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(i_imem_rvalid);
         r_discard     <= r_discard - CNT_W'(w_drop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]   <= r_resp_pc;
         r_q_data[r_wr_ptr] <= i_imem_rdata;
      end
   end

   // A response with nothing outstanding means the memory broke the protocol.
   always_ff @(posedge i_clk) begin
      if (i_rst_n)
         assert (!(i_imem_rvalid && (r_outstanding == '0)));
   end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order memory model that answers
// one cycle after acceptance (data = addr + 0x1000) unless responses are held.
module tb_fetch_prefetch;

   logic        clk;
   logic        rst_n;
   logic        irq;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pending[$];
   logic        rsp_en   = 1'b1;
   logic        seen_80  = 1'b0;

   fetch_prefetch dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_irq          (irq),
      .i_redirect     (redirect),
      .i_redirect_pc  (redirect_pc),
      .i_stall        (stall),
      .o_imem_req     (imem_req),
      .o_imem_addr    (imem_addr),
      .i_imem_ready   (imem_ready),
      .i_imem_rvalid  (imem_rvalid),
      .i_imem_rdata   (imem_rdata),
      .o_inst_valid   (inst_valid),
      .o_inst         (inst),
      .o_inst_pc      (inst_pc),
      .o_inst_pc_plus (inst_pc_plus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample the handshake before the edge, then update the memory model.
   task automatic tick();
      logic        acc;
      logic        rv;
      logic [31:0] a;
      acc = imem_req & imem_ready;
      rv  = imem_rvalid;
      a   = imem_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pending.delete();
         imem_rvalid = 1'b0;
      end else begin
         if (rv && pending.size() > 0) void'(pending.pop_front());
         if (acc) begin
            pending.push_back(a);
            if (a == 32'h80) seen_80 = 1'b1;
         end
         if (rsp_en && pending.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pending[0] + 32'h1000;
         end else begin
            imem_rvalid = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      irq         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      #12;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);

      // Streaming from reset
      rst_n = 1'b1;
      #1;
      chk("t1_req0", {31'b0, imem_req}, 32'd1);
      chk("t1_addr0", imem_addr, 32'd0);
      tick();
      chk("t1_valid_early", {31'b0, inst_valid}, 32'd0);
      chk("t1_addr1", imem_addr, 32'd1);
      tick();
      chk("t1_first_valid", {31'b0, inst_valid}, 32'd1);
      chk("t1_first_inst", inst, 32'h1000);
      chk("t1_first_pc", inst_pc, 32'd0);
      chk("t1_first_pc_plus", inst_pc_plus, 32'd1);
      chk("t1_addr2", imem_addr, 32'd2);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t1_stream_pc%0d", k), inst_pc, 32'(k));
         chk($sformatf("t1_stream_inst%0d", k), inst, 32'h1000 + 32'(k));
         chk($sformatf("t1_stream_addr%0d", k), imem_addr, 32'(k + 2));
      end

      // Stall until the queue fills
      stall = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("t2_full_req", {31'b0, imem_req}, 32'd0);
      chk("t2_full_addr", imem_addr, 32'd8);
      chk("t2_full_head", inst_pc, 32'd4);
      chk("t2_no_rvalid", {31'b0, imem_rvalid}, 32'd0);
      chk("t2_count", 32'(dut.r_count), 32'd4);
      stall = 1'b0;
      #1;
      tick();
      stall = 1'b1;
      #1;
      chk("t2_pop_head", inst_pc, 32'd5);
      chk("t2_new_req", {31'b0, imem_req}, 32'd1);
      chk("t2_new_addr", imem_addr, 32'd8);
      tick();
      chk("t2_one_req_a", {31'b0, imem_req}, 32'd0);
      tick();
      chk("t2_one_req_b", {31'b0, imem_req}, 32'd0);
      chk("t2_refull_count", 32'(dut.r_count), 32'd4);

      // Redirect with responses in flight
      stall       = 1'b0;
      rsp_en      = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'd8;
      #1;
      chk("t3_flush_req", {31'b0, imem_req}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t3_empty", {31'b0, inst_valid}, 32'd0);
      chk("t3_addr8", imem_addr, 32'd8);
      tick();
      tick();
      rsp_en = 1'b1;
      tick();
      chk("t3_outstanding3", 32'(dut.r_outstanding), 32'd3);
      chk("t3_rdata8", imem_rdata, 32'h1008);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      chk("t3_discard2", 32'(dut.r_discard), 32'd2);
      chk("t3_addr40", imem_addr, 32'h40);
      chk("t3_valid_a", {31'b0, inst_valid}, 32'd0);
      tick();
      chk("t3_valid_b", {31'b0, inst_valid}, 32'd0);
      tick();
      chk("t3_valid_c", {31'b0, inst_valid}, 32'd0);
      chk("t3_discard0", 32'(dut.r_discard), 32'd0);
      tick();
      chk("t3_valid_d", {31'b0, inst_valid}, 32'd1);
      chk("t3_pc40", inst_pc, 32'h40);
      chk("t3_inst40", inst, 32'h1040);

      // Interrupt beats redirect
      irq         = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      #1;
      chk("t4_flush_req", {31'b0, imem_req}, 32'd0);
      tick();
      irq      = 1'b0;
      redirect = 1'b0;
      #1;
      chk("t4_empty", {31'b0, inst_valid}, 32'd0);
      chk("t4_addr100", imem_addr, 32'h100);
      tick();
      chk("t4_valid_early", {31'b0, inst_valid}, 32'd0);
      tick();
      chk("t4_pc100", inst_pc, 32'h100);
      chk("t4_inst100", inst, 32'h1100);
      chk("t4_pc_plus", inst_pc_plus, 32'h101);
      chk("t4_no_80", {31'b0, seen_80}, 32'd0);

      // Memory back-pressure
      imem_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t5_hold_req%0d", k), {31'b0, imem_req}, 32'd1);
         chk($sformatf("t5_hold_addr%0d", k), imem_addr, 32'h102);
         tick();
      end
      chk("t5_hold_fetch_pc", 32'(dut.r_fetch_pc), 32'h102);
      chk("t5_hold_outstanding", 32'(dut.r_outstanding), 32'd0);
      imem_ready = 1'b1;
      #1;
      tick();
      imem_ready = 1'b0;
      #1;
      chk("t5_step_addr", imem_addr, 32'h103);
      chk("t5_step_outstanding", 32'(dut.r_outstanding), 32'd1);
      imem_ready = 1'b1;

      // Asynchronous reset with a half-full queue
      stall = 1'b1;
      #1;
      tick();
      tick();
      chk("t6_half_count", 32'(dut.r_count), 32'd2);
      chk("t6_half_head", inst_pc, 32'h102);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
      chk("t6_rst_inst", inst, 32'd0);
      stall = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
      chk("t6_restart_addr", imem_addr, 32'd0);
      tick();
      tick();
      chk("t6_restart_pc", inst_pc, 32'd0);
      chk("t6_restart_inst", inst, 32'h1000);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      chk("t6_addr_max", imem_addr, 32'hFFFF_FFFF);
      tick();
      chk("t6_addr_wrap", imem_addr, 32'd0);
      tick();
      chk("t6_wrap_pc", inst_pc, 32'hFFFF_FFFF);
      chk("t6_wrap_inst", inst, 32'h0000_0FFF);
      chk("t6_wrap_pc_plus", inst_pc_plus, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
